// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the unified memory and the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mips32_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port unified memory arbiter: data port has priority, instruction fetch
// is protected by a starvation guard, and fetch stall cycles are counted.
module mips32_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int STALL_W    = 16
) (
  input  logic               clk1,
  input  logic               rst,
  mips32_mem_arbiter_if.slave bus,
  output logic [STALL_W-1:0] i_stall_cnt
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } owner_e;

  owner_e             owner_r, owner_s;
  logic               store_r, store_s;
  logic [SC_W-1:0]    starve_r, starve_s;
  logic [STALL_W-1:0] stall_r, stall_s;

  logic i_ack_s, d_ack_s, i_elig_s, d_elig_s, grant_i_s, grant_d_s;

  // Ack decode from owner, eligibility and the single-grant decision
  always_comb begin
    i_ack_s   = (owner_r == OWN_INST);
    d_ack_s   = (owner_r == OWN_DATA);
    i_elig_s  = bus.i_req & ~i_ack_s & ~rst;
    d_elig_s  = bus.d_req & ~d_ack_s & ~rst;
    // Data wins a tie unless IF has already waited out STARVE_MAX data grants
    grant_d_s = d_elig_s & ~(i_elig_s & (starve_r == STARVE_LIM));
    grant_i_s = i_elig_s & ~grant_d_s;
  end

  // Next owner, starvation counter and saturating stall counter
  always_comb begin
    owner_s  = OWN_NONE;
    store_s  = 1'b0;
    starve_s = starve_r;
    stall_s  = stall_r;
    if (grant_d_s) begin
      owner_s = OWN_DATA;
      store_s = bus.d_we;
    end else if (grant_i_s) begin
      owner_s = OWN_INST;
    end else begin
      owner_s = OWN_NONE;
    end

    if (!bus.i_req || grant_i_s) begin
      starve_s = {SC_W{1'b0}};
    end else if (grant_d_s && i_elig_s && (starve_r != STARVE_LIM)) begin
      starve_s = starve_r + {{(SC_W-1){1'b0}}, 1'b1};
    end else begin
      starve_s = starve_r;
    end

    if (i_elig_s && grant_d_s && (stall_r != {STALL_W{1'b1}})) begin
      stall_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_s = stall_r;
    end
  end

  // State registers; reset drops any in-flight access without an ack
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      owner_r  <= OWN_NONE;
      store_r  <= 1'b0;
      starve_r <= {SC_W{1'b0}};
      stall_r  <= {STALL_W{1'b0}};
    end else begin
      owner_r  <= owner_s;
      store_r  <= store_s;
      starve_r <= starve_s;
      stall_r  <= stall_s;
    end
  end

  // Response and memory-side outputs
  always_comb begin
    bus.i_ack     = i_ack_s;
    bus.d_ack     = d_ack_s;
    bus.i_rdata   = {DATA_W{1'b0}};
    bus.d_rdata   = {DATA_W{1'b0}};
    bus.mem_en    = grant_d_s | grant_i_s;
    bus.mem_we    = grant_d_s & bus.d_we;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (i_ack_s) begin
      bus.i_rdata = bus.mem_rdata;
    end else begin
      bus.i_rdata = {DATA_W{1'b0}};
    end
    // Stores complete with a zero data word
    if (d_ack_s && !store_r) begin
      bus.d_rdata = bus.mem_rdata;
    end else begin
      bus.d_rdata = {DATA_W{1'b0}};
    end
    if (grant_d_s) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (grant_i_s) begin
      bus.mem_addr  = bus.i_addr;
    end else begin
      bus.mem_addr  = {ADDR_W{1'b0}};
    end
  end

  assign i_stall_cnt = stall_r;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed plus randomized bench for mips32_mem_arbiter, checked every cycle
// against a transaction-level reference model with its own shadow memory.
module tb_mips32_mem_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int STALL_W    = 4;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int STALL_SAT  = (1 << STALL_W) - 1;

  logic               clk1 = 1'b0;
  logic               rst  = 1'b1;
  logic [STALL_W-1:0] i_stall_cnt;

  mips32_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips32_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .STALL_W(STALL_W)
  ) dut (
    .clk1(clk1), .rst(rst), .bus(bus), .i_stall_cnt(i_stall_cnt)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] init_word(input int k);
    if (k == 5) return 32'h2801000a;
    return (32'(k) * 32'h9E3779B9) ^ 32'h5bd1e995;
  endfunction

  // Synchronous single-port memory behind the arbiter
  logic [31:0] mem_arr [0:DEPTH-1];
  logic [31:0] rd_q;
  logic        mem_ready = 1'b0;
  always @(posedge clk1) begin
    if (!mem_ready) begin
      for (int k = 0; k < DEPTH; k++) mem_arr[k] <= init_word(k);
      mem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      rd_q <= mem_arr[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  // Reference model: which transaction completes this cycle and with what data
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          m_iack, m_dack, m_dstore;
  logic [31:0] m_idata, m_ddata;
  int          m_starve, m_stall;
  bit          ie, de, g_i, g_d;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_iack = 0; m_dack = 0; m_dstore = 0;
    m_idata = 32'h0; m_ddata = 32'h0;
    m_starve = 0; m_stall = 0;
  endtask

  // Settle inputs, predict this cycle's grant and compare every output
  task automatic cyc_begin();
    #1;
    if (rst) model_reset();
    ie  = bus.i_req && !m_iack && !rst;
    de  = bus.d_req && !m_dack && !rst;
    g_d = de && !(ie && m_starve == STARVE_MAX);
    g_i = ie && !g_d;
    check("mem_en", 64'(bus.mem_en), 64'(g_d || g_i));
    check("mem_we", 64'(bus.mem_we), 64'(g_d && bus.d_we));
    if (g_d) begin
      check("mem_addr_d", 64'(bus.mem_addr), 64'(bus.d_addr));
      check("mem_wdata_d", 64'(bus.mem_wdata), 64'(bus.d_wdata));
    end
    if (g_i) check("mem_addr_i", 64'(bus.mem_addr), 64'(bus.i_addr));
    if (rst) begin
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    end
    check("i_ack", 64'(bus.i_ack), 64'(m_iack));
    check("i_rdata", 64'(bus.i_rdata), 64'(m_iack ? m_idata : 32'h0));
    check("d_ack", 64'(bus.d_ack), 64'(m_dack));
    check("d_rdata", 64'(bus.d_rdata), 64'((m_dack && !m_dstore) ? m_ddata : 32'h0));
    check("i_stall_cnt", 64'(i_stall_cnt), 64'(m_stall));
  endtask

  // Clock edge: retire the predicted grant into the model
  task automatic cyc_end();
    @(posedge clk1);
    if (rst) begin
      model_reset();
    end else begin
      m_iack = g_i;
      m_dack = g_d;
      m_dstore = g_d && bus.d_we;
      if (g_i) m_idata = ref_mem[bus.i_addr];
      if (g_d) begin
        m_ddata = ref_mem[bus.d_addr];
        if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
      end
      if (!bus.i_req || g_i) m_starve = 0;
      else if (g_d && ie && m_starve < STARVE_MAX) m_starve++;
      if (ie && g_d && m_stall < STALL_SAT) m_stall++;
    end
    #1;
  endtask

  task automatic cyc();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
    model_reset();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    @(posedge clk1);
    #1;
    cyc_begin();
    check("reset_i_ack", 64'(bus.i_ack), 64'd0);
    check("reset_stall", 64'(i_stall_cnt), 64'd0);
    cyc_end();
    rst = 1'b0;

    // Single fetch
    bus.i_req = 1'b1; bus.i_addr = 10'd5;
    cyc_begin();
    check("fetch_en", 64'(bus.mem_en), 64'd1);
    check("fetch_addr", 64'(bus.mem_addr), 64'd5);
    cyc_end();
    cyc_begin();
    check("fetch_ack", 64'(bus.i_ack), 64'd1);
    check("fetch_data", 64'(bus.i_rdata), 64'h2801000a);
    check("fetch_stall", 64'(i_stall_cnt), 64'd0);
    cyc_end();
    bus.i_req = 1'b0;

    // Store then load to the same word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd12; bus.d_wdata = 32'h37;
    cyc();
    cyc_begin();
    check("sw_ack", 64'(bus.d_ack), 64'd1);
    check("sw_rdata", 64'(bus.d_rdata), 64'd0);
    cyc_end();
    bus.d_we = 1'b0;
    cyc();
    cyc_begin();
    check("lw_ack", 64'(bus.d_ack), 64'd1);
    check("lw_rdata", 64'(bus.d_rdata), 64'h37);
    cyc_end();
    bus.d_req = 1'b0;

    // Simultaneous requests: data first, fetch granted during the data ack
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 10'd0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd3;
    cyc_begin();
    check("sim_grant_addr", 64'(bus.mem_addr), 64'd3);
    cyc_end();
    bus.d_req = 1'b0;
    cyc_begin();
    check("sim_d_ack", 64'(bus.d_ack), 64'd1);
    check("sim_i_grant_en", 64'(bus.mem_en), 64'd1);
    check("sim_i_grant_addr", 64'(bus.mem_addr), 64'd0);
    cyc_end();
    bus.i_req = 1'b0;
    cyc_begin();
    check("sim_i_ack", 64'(bus.i_ack), 64'd1);
    check("sim_stall", 64'(i_stall_cnt), 64'd1);
    cyc_end();

    // Data re-requests right after every ack while fetch is held pending
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 10'd7;
    for (int c = 0; c < 12; c++) begin
      if (!bus.d_req || m_dack) begin
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'($urandom_range(0, 31));
      end
      cyc();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // Reset in the cycle after a data grant
    do_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd20; bus.d_wdata = 32'h0000abcd;
    cyc();
    rst = 1'b1;
    cyc_begin();
    check("rst_mid_d_ack", 64'(bus.d_ack), 64'd0);
    check("rst_mid_mem_en", 64'(bus.mem_en), 64'd0);
    check("rst_mid_stall", 64'(i_stall_cnt), 64'd0);
    cyc_end();
    rst = 1'b0;
    cyc_begin();
    check("rst_reissue_en", 64'(bus.mem_en), 64'd1);
    cyc_end();
    cyc_begin();
    check("rst_reissue_ack", 64'(bus.d_ack), 64'd1);
    cyc_end();
    bus.d_req = 1'b0;

    // Stall counter saturation
    do_reset();
    for (int r = 0; r < 20; r++) begin
      bus.i_req = 1'b1; bus.i_addr = 10'($urandom_range(0, 63));
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'($urandom_range(0, 63));
      cyc();
      bus.d_req = 1'b0;
      cyc();
      bus.i_req = 1'b0;
      cyc();
    end
    cyc_begin();
    check("stall_saturated", 64'(i_stall_cnt), 64'(STALL_SAT));
    cyc_end();

    // Randomized traffic with periodic resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 19 == 18) begin
        bus.i_req = 1'($urandom_range(0, 1));
        bus.d_req = 1'($urandom_range(0, 1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end else begin
        if (!bus.i_req || m_iack) begin
          bus.i_req  = ($urandom_range(0, 3) != 0);
          bus.i_addr = 10'($urandom_range(0, 15));
        end
        if (!bus.d_req || m_dack) begin
          bus.d_req   = ($urandom_range(0, 3) != 0);
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_addr  = 10'($urandom_range(0, 15));
          bus.d_wdata = $urandom;
        end
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
